// File: rtl/async_fifo_rd_stream_pkg.sv
// async_fifo_pkg: shared types and constants for the async_fifo read side.
//   DEF_DATA_WIDTH / DEF_BUF_DEPTH : default word width and skid depth
//   OCC_W                          : occupancy width for the default depth
//   RD_LATENCY                     : async_fifo rd_en -> rd_data latency
//   data_t                         : default-width FIFO word
//   run_state_e                    : read-enable gating state after reset
//   occ_width()                    : occupancy width for an arbitrary depth
package async_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_BUF_DEPTH  = 3;
  localparam int unsigned OCC_W          = $clog2(DEF_BUF_DEPTH + 1);
  localparam int unsigned RD_LATENCY     = 1;

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;

  typedef enum logic {
    RUN_HOLD   = 1'b0,
    RUN_ACTIVE = 1'b1
  } run_state_e;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/async_fifo_rd_stream_if.sv
// async_fifo_rd_stream_if: valid/ready stream carrying FIFO words.
//   m_valid : word present (driven by master)
//   m_ready : consumer accepts (driven by slave)
//   m_data  : word payload (driven by master)
interface async_fifo_rd_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/async_fifo_rd_stream_skid.sv
// async_fifo_rd_skid: BUF_DEPTH-entry register ring buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : drop all entries (wins over push/pop)
//   push       : write push_data at the tail
//   pop        : remove the head entry
//   head_data  : registered copy of the head entry; holds its last value when empty
//   occupancy  : number of entries held
module async_fifo_rd_skid
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BUF_DEPTH  = DEF_BUF_DEPTH,
  localparam int unsigned OW        = occ_width(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OW-1:0]         occupancy
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  ptr_t                  head_q, head_d;
  ptr_t                  tail_q, tail_d;
  ptr_t                  head_nxt;
  logic [OW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;

  // Explicit wrap: depth need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(BUF_DEPTH - 1)) return '0;
    return p + ptr_t'(1);
  endfunction

  always_comb begin
    mem_d       = mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    head_data_d = head_data_q;
    head_nxt    = ptr_inc(head_q);

    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_data;
        tail_d        = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = head_nxt;
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + OW'(1);
        2'b01:   count_d = count_q - OW'(1);
        default: count_d = count_q;
      endcase

      // head_data is a separate register so m_data is a clean flop output
      // and keeps its last value once the buffer drains. On a pop with a
      // single entry the new head is the word being pushed this same edge.
      if (pop) begin
        if (count_q > OW'(1)) begin
          head_data_d = mem_q[head_nxt];
        end else if (push) begin
          head_data_d = push_data;
        end
      end else if (push && (count_q == '0)) begin
        head_data_d = push_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q       <= '{default: '0};
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      head_data_q <= '0;
    end else begin
      mem_q       <= mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      head_data_q <= head_data_d;
    end
  end

  assign head_data = head_data_q;
  assign occupancy = count_q;

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= OW'(BUF_DEPTH));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !pop && !clear) |-> (count_q < OW'(BUF_DEPTH)));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (pop && !clear) |-> (count_q != '0));

endmodule

// File: rtl/async_fifo_rd_stream.sv
// async_fifo_rd_stream: read-side adapter from async_fifo pull interface to
// a registered valid/ready stream.
//   rd_clk, rst_n : read-domain clock, asynchronous active-low reset
//   fifo_empty    : async_fifo empty
//   fifo_rd_en    : async_fifo rd_en (never depends on m_ready)
//   fifo_rd_data  : async_fifo rd_data, valid one cycle after fifo_rd_en
//   m_if          : outgoing stream (m_valid, m_ready, m_data)
//   flush         : drop buffered and in-flight words
//   occupancy     : words held in the skid buffer
//   xfer_cnt      : completed stream transfers, wraps silently
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BUF_DEPTH  = DEF_BUF_DEPTH,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned OW        = occ_width(BUF_DEPTH)
) (
  input  logic                          rd_clk,
  input  logic                          rst_n,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]         fifo_rd_data,
  async_fifo_rd_stream_if.master        m_if,
  input  logic                          flush,
  output logic [OW-1:0]                 occupancy,
  output logic [CNT_WIDTH-1:0]          xfer_cnt
);

  run_state_e           run_q, run_d;
  logic                 in_flight_q, in_flight_d;
  logic                 discard_q, discard_d;
  logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [OW:0]          fill;
  logic                 room;
  logic                 capture;
  logic                 pop;
  logic                 m_valid;
  logic [DATA_WIDTH-1:0] head_data;

  // Reads are held off for the release cycle, then enabled for good.
  always_comb begin
    run_d = run_q;
    unique case (run_q)
      RUN_HOLD:   run_d = RUN_ACTIVE;
      RUN_ACTIVE: run_d = RUN_ACTIVE;
      default:    run_d = RUN_HOLD;
    endcase
  end

  always_comb begin
    fill        = {1'b0, occupancy} + {{OW{1'b0}}, in_flight_q};
    room        = fill < (OW + 1)'(BUF_DEPTH);
    // Issue depends on registered state and flush only, never on m_ready.
    fifo_rd_en  = (run_q == RUN_ACTIVE) && !fifo_empty && !flush && room;
    in_flight_d = fifo_rd_en;
    // A word landing in the flush cycle is dropped by the clear itself;
    // discard also masks the cycle after so no stale capture survives.
    discard_d   = flush && in_flight_q;
    capture     = in_flight_q && !discard_q && !flush;
    pop         = m_valid && m_if.m_ready && !flush;
    xfer_cnt_d  = xfer_cnt_q;
    if (pop) begin
      xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= RUN_HOLD;
      in_flight_q <= 1'b0;
      discard_q   <= 1'b0;
      xfer_cnt_q  <= '0;
    end else begin
      run_q       <= run_d;
      in_flight_q <= in_flight_d;
      discard_q   <= discard_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  async_fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_skid (
    .clk        (rd_clk),
    .rst_n      (rst_n),
    .clear      (flush),
    .push       (capture),
    .push_data  (fifo_rd_data),
    .pop        (pop),
    .head_data  (head_data),
    .occupancy  (occupancy)
  );

  assign m_valid     = (occupancy != '0);
  assign m_if.m_valid = m_valid;
  assign m_if.m_data  = head_data;
  assign xfer_cnt     = xfer_cnt_q;

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
module tb_async_fifo_rd_stream;
  import async_fifo_pkg::*;

  localparam int unsigned CW = 4;

  logic              rd_clk = 1'b0;
  logic              rst_n;
  logic              fifo_empty;
  logic              fifo_rd_en;
  data_t             fifo_rd_data = '0;
  logic              flush;
  logic [OCC_W-1:0]  occupancy;
  logic [CW-1:0]     xfer_cnt;

  async_fifo_rd_stream_if #(.DATA_WIDTH(DEF_DATA_WIDTH)) m_if ();

  async_fifo_rd_stream #(
    .DATA_WIDTH (DEF_DATA_WIDTH),
    .BUF_DEPTH  (DEF_BUF_DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .rd_clk       (rd_clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_if         (m_if.master),
    .flush        (flush),
    .occupancy    (occupancy),
    .xfer_cnt     (xfer_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model: stimulus appends, model reads by index with 1-cycle latency.
  data_t       fifo_mem [$];
  int unsigned wr_cnt = 0;
  int unsigned rd_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_cnt);

  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      if (rd_ptr < wr_cnt) fifo_rd_data <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Scoreboard (written by stimulus only) and direct-check records.
  data_t       exp_q [$];
  string       chk_name [$];
  int unsigned chk_act [$];
  int unsigned chk_exp [$];

  // Monitor-owned state.
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned chk_idx  = 0;
  int unsigned mon_idx  = 0;
  logic [CW-1:0] exp_cnt = '0;

  always @(negedge rd_clk) begin
    while (chk_idx < chk_name.size()) begin
      n_assert++;
      if (chk_act[chk_idx] != chk_exp[chk_idx]) begin
        n_fail++;
        $display("FAIL %s: actual %0h required %0h", chk_name[chk_idx],
                 chk_act[chk_idx], chk_exp[chk_idx]);
      end
      chk_idx++;
    end
    if (!rst_n) begin
      exp_cnt = '0;
    end else begin
      n_assert++;
      if (xfer_cnt != exp_cnt) begin
        n_fail++;
        $display("FAIL xfer_cnt: actual %0d required %0d", xfer_cnt, exp_cnt);
      end
      if (fifo_rd_en) begin
        n_assert++;
        if (fifo_empty) begin
          n_fail++;
          $display("FAIL rd_en_while_empty: actual empty=1 required empty=0");
        end
      end
      if (m_if.m_valid && m_if.m_ready && !flush) begin
        n_assert++;
        if (mon_idx >= exp_q.size()) begin
          n_fail++;
          $display("FAIL unexpected_transfer: actual data %0h required no transfer", m_if.m_data);
        end else if (m_if.m_data != exp_q[mon_idx]) begin
          n_fail++;
          $display("FAIL stream_data[%0d]: actual %0h required %0h", mon_idx,
                   m_if.m_data, exp_q[mon_idx]);
        end
        mon_idx++;
        exp_cnt = exp_cnt + CW'(1);
      end
    end
  end

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    chk_name.push_back(name);
    chk_act.push_back(act);
    chk_exp.push_back(exp);
  endtask

  task automatic load(input data_t d, input bit delivered);
    fifo_mem.push_back(d);
    wr_cnt++;
    if (delivered) exp_q.push_back(d);
  endtask

  task automatic wait_valid();
    int unsigned n = 0;
    while (!m_if.m_valid && n < 10) begin
      tick();
      n++;
    end
    check("valid_timeout", m_if.m_valid, 1);
  endtask

  task automatic wait_idle();
    int unsigned stable = 0;
    int unsigned n = 0;
    while (stable < 3 && n < 300) begin
      tick();
      n++;
      if (fifo_empty && occupancy == '0 && !m_if.m_valid) stable++;
      else stable = 0;
    end
    check("drain_timeout", (stable >= 3) ? 1 : 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1);
  end

  initial begin
    int unsigned bubbles;
    rst_n        = 1'b0;
    flush        = 1'b0;
    m_if.m_ready = 1'b1;

    // 1: reset release with 5 words waiting
    for (int i = 0; i < 5; i++) load(data_t'(8'h10 + i), 1'b1);
    repeat (3) begin
      tick();
      check("rd_en_in_reset", fifo_rd_en, 0);
    end
    check("reset_m_valid", m_if.m_valid, 0);
    check("reset_m_data", m_if.m_data, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_xfer_cnt", xfer_cnt, 0);
    rst_n = 1'b1;
    #1;
    check("rd_en_release_cycle", fifo_rd_en, 0);
    tick();
    check("rd_en_first", fifo_rd_en, 1);
    for (int k = 1; k <= 2 + int'(RD_LATENCY); k++) begin
      if (k > 1) tick();
      check("first_valid_latency", m_if.m_valid, (k == 2 + int'(RD_LATENCY)) ? 1 : 0);
    end
    repeat (4) begin
      tick();
      check("t1_back_to_back", m_if.m_valid, 1);
    end
    tick();
    check("t1_valid_end", m_if.m_valid, 0);
    check("t1_xfer_cnt", xfer_cnt, 5);

    // 2 + 4: 100-word stream, one word per cycle
    for (int i = 0; i < 100; i++) load(data_t'(i), 1'b1);
    wait_valid();
    bubbles = 0;
    for (int j = 0; j < 100; j++) begin
      if (!m_if.m_valid) bubbles++;
      if (j == 50) begin
        check("steady_occupancy", occupancy, 1);
        check("steady_rd_en", fifo_rd_en, 1);
      end
      if (j >= 50 && j <= 52) check("steady_m_data", m_if.m_data, j);
      tick();
    end
    check("bubbles", bubbles, 0);
    wait_idle();

    // 3: backpressure
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) load(data_t'(8'h40 + i), 1'b1);
    repeat (8) tick();
    check("bp_occupancy", occupancy, 3);
    check("bp_rd_en", fifo_rd_en, 0);
    check("bp_fifo_left", wr_cnt - rd_ptr, 7);
    check("bp_m_valid", m_if.m_valid, 1);
    check("bp_head", m_if.m_data, 8'h40);
    tick();
    check("bp_head_held", m_if.m_data, 8'h40);
    m_if.m_ready = 1'b1;
    wait_idle();

    // 5: flush with occupancy=2, one word in flight
    m_if.m_ready = 1'b0;
    load(8'h50, 1'b0);
    load(8'h51, 1'b0);
    load(8'h52, 1'b0);
    repeat (3) tick();
    check("pre_flush_occupancy", occupancy, 2);
    flush = 1'b1;
    load(8'h53, 1'b1);
    #1;
    check("flush_rd_en", fifo_rd_en, 0);
    tick();
    flush = 1'b0;
    check("post_flush_m_valid", m_if.m_valid, 0);
    check("post_flush_occupancy", occupancy, 0);
    tick();
    check("discard_occupancy", occupancy, 0);
    m_if.m_ready = 1'b1;
    wait_idle();

    // 6: reset mid-stream, then 17 transfers on a 4-bit counter
    m_if.m_ready = 1'b0;
    load(8'h60, 1'b0);
    load(8'h61, 1'b0);
    repeat (3) tick();
    check("pre_reset_occupancy", occupancy, 2);
    rst_n = 1'b0;
    load(8'h62, 1'b1);
    #1;
    check("mid_reset_m_valid", m_if.m_valid, 0);
    check("mid_reset_occupancy", occupancy, 0);
    check("mid_reset_xfer_cnt", xfer_cnt, 0);
    check("mid_reset_rd_en", fifo_rd_en, 0);
    repeat (2) begin
      tick();
      check("mid_reset_rd_en", fifo_rd_en, 0);
    end
    rst_n = 1'b1;
    m_if.m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) load(data_t'(8'h62 + i), 1'b1);
    wait_idle();
    check("xfer_cnt_wrap", xfer_cnt, 1);

    tick();
    tick();
    check("scoreboard_drained", mon_idx, exp_q.size());
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
